// File: rtl/cbb_rr_stream_arbiter.sv
// N-to-1 round-robin arbiter for valid/ready streams with packet locking on last.
// A registered forward slice drives the master port and tags each beat with its source index.
module cbb_rr_stream_arbiter #(
    parameter int P_NUM_SLV    = 4,
    parameter int P_DATA_WIDTH = 64,
    parameter int P_ID_WIDTH   = 2
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [P_NUM_SLV-1:0]              slv_i_valid,
    input  logic [P_NUM_SLV*P_DATA_WIDTH-1:0] slv_i_data,
    input  logic [P_NUM_SLV-1:0]              slv_i_last,
    output logic [P_NUM_SLV-1:0]              slv_o_ready,
    output logic                              mst_o_valid,
    output logic [P_DATA_WIDTH-1:0]           mst_o_data,
    output logic                              mst_o_last,
    output logic [P_ID_WIDTH-1:0]             mst_o_id,
    input  logic                              mst_i_ready
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [P_ID_WIDTH-1:0]   rr_ptr;
    logic [P_ID_WIDTH-1:0]   lock_id;
    logic [P_ID_WIDTH-1:0]   rr_sel;
    logic [P_ID_WIDTH-1:0]   low_sel;
    logic [P_ID_WIDTH-1:0]   sel;
    logic                    hi_found;
    logic                    sel_vld;
    logic                    sel_last;
    logic [P_DATA_WIDTH-1:0] sel_data;
    logic                    out_rdy;
    logic                    accept;

    assign out_rdy = mst_i_ready | ~mst_o_valid;
    assign accept  = out_rdy & sel_vld & ~i_rst;

    // Modulo scan from rr_ptr+1: lowest requester above rr_ptr, otherwise wrap to the lowest overall.
    always_comb begin
        low_sel  = '0;
        rr_sel   = '0;
        hi_found = 1'b0;
        for (int unsigned k = P_NUM_SLV; k > 0; k--) begin
            if (slv_i_valid[k-1]) begin
                low_sel = P_ID_WIDTH'(k - 1);
                if (P_ID_WIDTH'(k - 1) > rr_ptr) begin
                    rr_sel   = P_ID_WIDTH'(k - 1);
                    hi_found = 1'b1;
                end
            end
        end
        if (!hi_found) begin
            rr_sel = low_sel;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            rr_ptr  <= P_ID_WIDTH'(P_NUM_SLV - 1);
            lock_id <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lock_id <= sel;
                if (sel_last) begin
                    rr_ptr <= sel;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !sel_last) state_nxt = LOCKED;
            LOCKED:  if (accept && sel_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sel     = rr_sel;
        sel_vld = |slv_i_valid;
        if (state == LOCKED) begin
            sel     = lock_id;
            sel_vld = slv_i_valid[lock_id];
        end
        sel_data    = '0;
        sel_last    = 1'b0;
        slv_o_ready = '0;
        for (int unsigned k = 0; k < P_NUM_SLV; k++) begin
            if (P_ID_WIDTH'(k) == sel) begin
                sel_data       = slv_i_data[k*P_DATA_WIDTH +: P_DATA_WIDTH];
                sel_last       = slv_i_last[k];
                slv_o_ready[k] = out_rdy & sel_vld & ~i_rst;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mst_o_valid <= 1'b0;
            mst_o_data  <= '0;
            mst_o_last  <= 1'b0;
            mst_o_id    <= '0;
        end else if (out_rdy) begin
            mst_o_valid <= accept;
            if (accept) begin
                mst_o_data <= sel_data;
                mst_o_last <= sel_last;
                mst_o_id   <= sel;
            end
        end
    end

endmodule

// File: tb/tb_cbb_rr_stream_arbiter.sv
// Self-checking bench for cbb_rr_stream_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a queue/integer reference model and a per-slave scoreboard.
module tb_cbb_rr_stream_arbiter;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   slv_i_valid;
    logic [N-1:0]   slv_i_last;
    logic [N-1:0]   slv_o_ready;
    logic [N*W-1:0] slv_i_data;
    logic [W-1:0]   s_data [N];
    logic           mst_o_valid;
    logic [W-1:0]   mst_o_data;
    logic           mst_o_last;
    logic [IW-1:0]  mst_o_id;
    logic           mst_i_ready;

    int n_checks = 0;
    int n_errors = 0;
    bit rand_mode = 1'b0;
    logic [N-1:0] rdy_s = '0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < N; k++) slv_i_data[k*W +: W] = s_data[k];
    end

    cbb_rr_stream_arbiter #(
        .P_NUM_SLV   (N),
        .P_DATA_WIDTH(W),
        .P_ID_WIDTH  (IW)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .slv_i_valid(slv_i_valid),
        .slv_i_data (slv_i_data),
        .slv_i_last (slv_i_last),
        .slv_o_ready(slv_o_ready),
        .mst_o_valid(mst_o_valid),
        .mst_o_data (mst_o_data),
        .mst_o_last (mst_o_last),
        .mst_o_id   (mst_o_id),
        .mst_i_ready(mst_i_ready)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: output register contents, locked source (-1 = none), last winner.
    logic     m_valid;
    logic     m_last;
    logic [W-1:0] m_data;
    int       m_id;
    int       m_lock;
    int       m_ptr;

    function automatic int exp_grant();
        if (rst) return -1;
        if (m_valid && !mst_i_ready) return -1;
        if (m_lock >= 0) return slv_i_valid[m_lock] ? m_lock : -1;
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (slv_i_valid[k]) return k;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int g;
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_id    <= 0;
            m_lock  <= -1;
            m_ptr   <= N - 1;
        end else begin
            g = exp_grant();
            if (!m_valid || mst_i_ready) begin
                m_valid <= (g >= 0);
                if (g >= 0) begin
                    m_data <= s_data[g];
                    m_last <= slv_i_last[g];
                    m_id   <= g;
                    if (slv_i_last[g]) begin
                        m_lock <= -1;
                        m_ptr  <= g;
                    end else begin
                        m_lock <= g;
                    end
                end
            end
        end
    end

    logic [W:0] sbq [N][$];
    int pkt_src = -1;

    always @(negedge clk) begin : cmp
        int g;
        int id;
        logic [N-1:0] er;
        logic [W:0] e;
        g  = exp_grant();
        er = (g >= 0) ? (N'(1) << g) : '0;
        check("slv_ready", W'(slv_o_ready), W'(er));
        check("ready_onehot0", W'($onehot0(slv_o_ready)), W'(1));
        check("mst_valid", W'(mst_o_valid), W'(m_valid));
        check("mst_data", mst_o_data, m_data);
        check("mst_last", W'(mst_o_last), W'(m_last));
        check("mst_id", W'(mst_o_id), W'(m_id));
        if (rst) begin
            foreach (sbq[k]) sbq[k].delete();
            pkt_src = -1;
        end else begin
            if (mst_o_valid && mst_i_ready) begin
                id = int'(mst_o_id);
                check("sb_nonempty", W'(sbq[id].size() != 0), W'(1));
                if (sbq[id].size() != 0) begin
                    e = sbq[id].pop_front();
                    check("sb_data", mst_o_data, e[W-1:0]);
                    check("sb_last", W'(mst_o_last), W'(e[W]));
                end
                if (pkt_src >= 0) check("pkt_interleave", W'(mst_o_id), W'(pkt_src));
                pkt_src = mst_o_last ? -1 : id;
            end
            for (int k = 0; k < N; k++) begin
                if (slv_i_valid[k] && slv_o_ready[k]) sbq[k].push_back({slv_i_last[k], s_data[k]});
            end
        end
        rdy_s = slv_o_ready;
    end

    // Directed sources bump their data after each accepted beat so duplicates are visible.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rand_mode) begin
            for (int k = 0; k < N; k++) if (rdy_s[k]) s_data[k] = s_data[k] + 1;
        end
    endtask

    initial begin
        mst_i_ready = 1'b1;
        slv_i_valid = '0;
        slv_i_last  = '0;
        for (int k = 0; k < N; k++) s_data[k] = '0;
        @(posedge clk);
        #1;

        // Reset held with every slave requesting
        slv_i_valid = '1;
        slv_i_last  = '1;
        for (int k = 0; k < N; k++) s_data[k] = W'(k) << 32;
        #1;
        check("t1_rst_valid", W'(mst_o_valid), W'(0));
        check("t1_rst_id", W'(mst_o_id), W'(0));
        check("t1_rst_ready", W'(slv_o_ready), W'(0));
        check("t1_rst_data", mst_o_data, W'(0));
        tick();
        rst = 1'b0;
        #1;
        check("t1_first_grant", W'(slv_o_ready), W'(4'b0001));
        check("t1_idle_valid", W'(mst_o_valid), W'(0));

        // Fairness: single-beat packets from all slaves rotate 0,1,2,3
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t2_valid", W'(mst_o_valid), W'(1));
            check("t2_id", W'(mst_o_id), W'(i % 4));
            check("t2_data", mst_o_data, (W'(i % 4) << 32) + W'(i / 4));
        end

        // Lock: slave 1 three-beat packet while slave 0 keeps requesting
        slv_i_valid = 4'b0001;
        tick();
        check("t3_pre_id", W'(mst_o_id), W'(0));
        slv_i_valid   = 4'b0011;
        s_data[1]     = 64'hD1A;
        slv_i_last[1] = 1'b0;
        #1;
        check("t3_ready_a", W'(slv_o_ready), W'(4'b0010));
        tick();
        check("t3_id_a", W'(mst_o_id), W'(1));
        check("t3_data_a", mst_o_data, 64'hD1A);
        s_data[1] = 64'hD1B;
        #1;
        check("t3_ready_b", W'(slv_o_ready), W'(4'b0010));
        tick();
        check("t3_id_b", W'(mst_o_id), W'(1));
        check("t3_data_b", mst_o_data, 64'hD1B);
        s_data[1]     = 64'hD1C;
        slv_i_last[1] = 1'b1;
        #1;
        check("t3_ready_c", W'(slv_o_ready), W'(4'b0010));
        tick();
        check("t3_id_c", W'(mst_o_id), W'(1));
        check("t3_data_c", mst_o_data, 64'hD1C);
        check("t3_last_c", W'(mst_o_last), W'(1));
        slv_i_valid[1] = 1'b0;
        #1;
        check("t3_release", W'(slv_o_ready), W'(4'b0001));
        tick();
        check("t3_next_id", W'(mst_o_id), W'(0));

        // Backpressure: hold 0xA5 on the master for five cycles
        s_data[0] = 64'hA5;
        #1;
        tick();
        check("t4_load", mst_o_data, 64'hA5);
        mst_i_ready = 1'b0;
        #1;
        check("t4_ready_off", W'(slv_o_ready), W'(0));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_data", mst_o_data, 64'hA5);
            check("t4_hold_valid", W'(mst_o_valid), W'(1));
            check("t4_hold_ready", W'(slv_o_ready), W'(0));
        end
        mst_i_ready = 1'b1;
        #1;
        check("t4_ready_on", W'(slv_o_ready), W'(4'b0001));
        tick();
        check("t4_next_data", mst_o_data, 64'hA6);

        // Reset in the middle of a four-beat packet from slave 2
        slv_i_valid   = 4'b0100;
        slv_i_last[2] = 1'b0;
        s_data[2]     = 64'hC1;
        #1;
        tick();
        check("t5_beat1", mst_o_data, 64'hC1);
        tick();
        check("t5_beat2", mst_o_data, 64'hC2);
        check("t5_beat2_id", W'(mst_o_id), W'(2));
        rst            = 1'b1;
        slv_i_valid[0] = 1'b1;
        #1;
        check("t5_rst_valid", W'(mst_o_valid), W'(0));
        check("t5_rst_ready", W'(slv_o_ready), W'(0));
        tick();
        rst = 1'b0;
        #1;
        check("t5_post_valid", W'(mst_o_valid), W'(0));
        check("t5_unlocked", W'(slv_o_ready), W'(4'b0001));
        tick();
        check("t5_winner", W'(mst_o_id), W'(0));
        check("t5_winner_valid", W'(mst_o_valid), W'(1));

        // Random traffic; sources hold while offered and unaccepted
        rand_mode = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!slv_i_valid[k] || rdy_s[k]) begin
                    slv_i_valid[k] = ($urandom_range(0, 3) != 0);
                    s_data[k]      = {$urandom, $urandom};
                    slv_i_last[k]  = ($urandom_range(0, 2) == 0);
                end
            end
            mst_i_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        slv_i_valid = '0;
        mst_i_ready = 1'b1;
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
